// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the pipeline/multi-cycle unit and the RF arbiter.
// The arbiter uses the slave modport; the pipeline-side driver uses master.
interface rf_wb_arbiter_if;
    logic        pw_valid;
    logic [4:0]  pw_addr;
    logic [31:0] pw_data;
    logic [31:0] pw_pc;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [31:0] md_pc;
    logic        md_ready;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc;
    logic [31:0] busy;
    logic        stall_req;

    modport slave (
        input  pw_valid, pw_addr, pw_data, pw_pc,
        input  md_valid, md_addr, md_data, md_pc,
        output md_ready, rf_wr, rf_a3, rf_wd, rf_pc, busy, stall_req
    );

    modport master (
        output pw_valid, pw_addr, pw_data, pw_pc,
        output md_valid, md_addr, md_data, md_pc,
        input  md_ready, rf_wr, rf_a3, rf_wd, rf_pc, busy, stall_req
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: W-stage writes win, multi-cycle results
// queue in a small FIFO, get squashed by younger writes, and drain on bubbles.
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             ready_q;

    logic             rf_wr_q, rf_wr_d;
    logic [4:0]       rf_a3_q, rf_a3_d;
    logic [31:0]      rf_wd_q, rf_wd_d, rf_pc_q, rf_pc_d;

    logic             full, md_ready, md_fire, pw_grant;
    logic             head_found, fifo_grant, bypass, enq;
    logic [CW-1:0]    head_off, pop_cnt;
    logic [PW-1:0]    head_idx;
    logic [31:0]      busy_v;

    assign full     = (count_q == CW'(DEPTH));
    assign md_ready = ready_q && !full;
    assign md_fire  = bus.md_valid && md_ready;
    assign pw_grant = bus.pw_valid && (bus.pw_addr != 5'd0);

    // First still-valid entry from the head; squashed entries ahead of it are skipped.
    always_comb begin
        head_found = 1'b0;
        head_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!head_found && (CW'(i) < count_q) && valid_q[rd_ptr_q + PW'(i)]) begin
                head_found = 1'b1;
                head_off   = CW'(i);
            end
        end
    end

    assign head_idx   = rd_ptr_q + head_off[PW-1:0];
    assign fifo_grant = !pw_grant && head_found;
    assign bypass     = !pw_grant && !head_found && md_fire && (bus.md_addr != 5'd0);
    assign enq        = md_fire && (bus.md_addr != 5'd0) && !bypass;
    assign pop_cnt    = fifo_grant ? head_off + CW'(1) : (head_found ? head_off : count_q);

    always_comb begin
        valid_d = valid_q;
        if (pw_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (addr_q[i] == bus.pw_addr)) valid_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < pop_cnt) valid_d[rd_ptr_q + PW'(i)] = 1'b0;
        end
        // The entry enqueued this cycle is younger than the pw write and stays valid.
        if (enq) valid_d[wr_ptr_q] = 1'b1;
    end

    assign rd_ptr_d = rd_ptr_q + pop_cnt[PW-1:0];
    assign wr_ptr_d = wr_ptr_q + PW'(enq);
    assign count_d  = count_q - pop_cnt + CW'(enq);

    always_comb begin
        starve_d = starve_q;
        if (fifo_grant || !head_found)                          starve_d = '0;
        else if (pw_grant && (starve_q != SW'(STARVE_MAX)))     starve_d = starve_q + SW'(1);
    end

    always_comb begin
        rf_wr_d = pw_grant || fifo_grant || bypass;
        rf_a3_d = rf_a3_q;
        rf_wd_d = rf_wd_q;
        rf_pc_d = rf_pc_q;
        if (pw_grant) begin
            rf_a3_d = bus.pw_addr;
            rf_wd_d = bus.pw_data;
            rf_pc_d = bus.pw_pc;
        end else if (fifo_grant) begin
            rf_a3_d = addr_q[head_idx];
            rf_wd_d = data_q[head_idx];
            rf_pc_d = pc_q[head_idx];
        end else if (bypass) begin
            rf_a3_d = bus.md_addr;
            rf_wd_d = bus.md_data;
            rf_pc_d = bus.md_pc;
        end
    end

    always_comb begin
        busy_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) busy_v[addr_q[i]] = 1'b1;
        end
        if (rf_wr_q) busy_v[rf_a3_q] = 1'b1;
        busy_v[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            ready_q  <= 1'b0;
            rf_wr_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd_q  <= '0;
            rf_pc_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            ready_q  <= 1'b1;
            rf_wr_q  <= rf_wr_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd_q  <= rf_wd_d;
            rf_pc_q  <= rf_pc_d;
        end
    end

    // Payload is only meaningful under valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= bus.md_addr;
            data_q[wr_ptr_q] <= bus.md_data;
            pc_q[wr_ptr_q]   <= bus.md_pc;
        end
    end

    assign bus.md_ready  = md_ready;
    assign bus.rf_wr     = rf_wr_q;
    assign bus.rf_a3     = rf_a3_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.rf_pc     = rf_pc_q;
    assign bus.busy      = busy_v;
    assign bus.stall_req = (starve_q == SW'(STARVE_MAX)) || (full && bus.md_valid);
endmodule
